// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// Consumer side of the EX/MEM pipeline register. Resolves the branch select
// for IF, runs each load/store as a req/ack transaction on the data memory
// port, stalls the upstream pipeline while an access is in flight, and drives
// the registered MEM/WB outputs.
//
// Ports
//   CLK, RST_N                 clock (posedge), asynchronous active-low reset
//   RegWrite, MemtoReg,
//   MemWrite, Branch, zero     EX/MEM control bits (MemtoReg=1 load,
//                              MemWrite=1 store)
//   ALUOut, WriteData,
//   WriteReg, PCBranch         EX/MEM data: address/result, store data,
//                              destination register, branch target
//   PCSrc, PCBranchOut         take-branch select and branch target to IF
//   stall                      hold PC, IF/ID, ID/EX, EX/MEM
//   dmem_req/we/addr/wdata     registered data-memory request
//   dmem_rdata, dmem_ack       read data, one-cycle completion pulse
//   mem_err                    one-cycle pulse: misaligned access or timeout
//   wb_*                       MEM/WB register outputs
//
// Timing
//   Non-memory op       : 1 cycle, no stall.
//   Misaligned memop    : 1 cycle, no request, squashed write-back + mem_err.
//   Aligned memop       : IDLE (stall) -> REQ x N (stall) -> RESP (no stall);
//                         write-back lands on the RESP edge.
//   Every stalled edge writes a bubble into MEM/WB (RegWrite=MemtoReg=0).
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        zero,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] PCBranch,
  output logic        PCSrc,
  output logic [31:0] PCBranchOut,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_err,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_ReadData,
  output logic [31:0] wb_ALUOut,
  output logic [4:0]  wb_WriteReg
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              abort_reg, abort_next;
  logic [31:0]       rdata_reg, rdata_next;

  // Control fields of the instruction owning the access, captured at launch
  // so the write-back does not depend on upstream holding EX/MEM into RESP.
  logic              hold_regwrite_reg, hold_regwrite_next;
  logic              hold_memtoreg_reg, hold_memtoreg_next;
  logic [4:0]        hold_writereg_reg, hold_writereg_next;

  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;

  logic              wb_regwrite_reg, wb_regwrite_next;
  logic              wb_memtoreg_reg, wb_memtoreg_next;
  logic [31:0]       wb_readdata_reg, wb_readdata_next;
  logic [31:0]       wb_aluout_reg, wb_aluout_next;
  logic [4:0]        wb_writereg_reg, wb_writereg_next;

  logic              memop;
  logic              misal;

  assign memop = MemtoReg | MemWrite;
  assign misal = memop & (ALUOut[1:0] != 2'b00);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      abort_reg         <= 1'b0;
      rdata_reg         <= '0;
      hold_regwrite_reg <= 1'b0;
      hold_memtoreg_reg <= 1'b0;
      hold_writereg_reg <= '0;
      req_reg           <= 1'b0;
      we_reg            <= 1'b0;
      addr_reg          <= '0;
      wdata_reg         <= '0;
      err_reg           <= 1'b0;
      wb_regwrite_reg   <= 1'b0;
      wb_memtoreg_reg   <= 1'b0;
      wb_readdata_reg   <= '0;
      wb_aluout_reg     <= '0;
      wb_writereg_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      abort_reg         <= abort_next;
      rdata_reg         <= rdata_next;
      hold_regwrite_reg <= hold_regwrite_next;
      hold_memtoreg_reg <= hold_memtoreg_next;
      hold_writereg_reg <= hold_writereg_next;
      req_reg           <= req_next;
      we_reg            <= we_next;
      addr_reg          <= addr_next;
      wdata_reg         <= wdata_next;
      err_reg           <= err_next;
      wb_regwrite_reg   <= wb_regwrite_next;
      wb_memtoreg_reg   <= wb_memtoreg_next;
      wb_readdata_reg   <= wb_readdata_next;
      wb_aluout_reg     <= wb_aluout_next;
      wb_writereg_reg   <= wb_writereg_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    abort_next         = abort_reg;
    rdata_next         = rdata_reg;
    hold_regwrite_next = hold_regwrite_reg;
    hold_memtoreg_next = hold_memtoreg_reg;
    hold_writereg_next = hold_writereg_reg;
    req_next           = req_reg;
    we_next            = we_reg;
    addr_next          = addr_reg;
    wdata_next         = wdata_reg;
    err_next           = 1'b0;
    // Bubble by default: any edge that does not retire an instruction writes
    // RegWrite=MemtoReg=0 and leaves the data fields where they were.
    wb_regwrite_next   = 1'b0;
    wb_memtoreg_next   = 1'b0;
    wb_readdata_next   = wb_readdata_reg;
    wb_aluout_next     = wb_aluout_reg;
    wb_writereg_next   = wb_writereg_reg;
    stall              = 1'b0;
    PCSrc              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (memop && !misal) begin
          // Launch the access; EX/MEM is frozen from this cycle on.
          stall              = 1'b1;
          state_next         = REQ;
          req_next           = 1'b1;
          we_next            = MemWrite;
          addr_next          = ALUOut;
          wdata_next         = WriteData;
          cnt_next           = '0;
          abort_next         = 1'b0;
          rdata_next         = '0;
          hold_regwrite_next = RegWrite;
          hold_memtoreg_next = MemtoReg;
          hold_writereg_next = WriteReg;
        end else begin
          // Plain op or misaligned memop retires this edge. A misaligned
          // access never reaches memory and its register write is squashed.
          wb_regwrite_next = RegWrite & ~misal;
          wb_memtoreg_next = MemtoReg;
          wb_readdata_next = '0;
          wb_aluout_next   = ALUOut;
          wb_writereg_next = WriteReg;
          err_next         = misal;
          // A memop that also claims Branch never redirects the PC.
          PCSrc            = Branch & zero & ~memop;
        end
      end

      REQ: begin
        stall = 1'b1;
        if (dmem_ack) begin
          rdata_next = we_reg ? 32'd0 : dmem_rdata;
          req_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          // TIMEOUT request cycles without an ack: give up on this access.
          req_next   = 1'b0;
          abort_next = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RESP: begin
        // Release the stall; the owning instruction retires on this edge.
        wb_regwrite_next = hold_regwrite_reg & ~abort_reg;
        wb_memtoreg_next = hold_memtoreg_reg;
        wb_readdata_next = rdata_reg;
        wb_aluout_next   = addr_reg;
        wb_writereg_next = hold_writereg_reg;
        err_next         = abort_reg;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign PCBranchOut = PCBranch;
  assign dmem_req    = req_reg;
  assign dmem_we     = we_reg;
  assign dmem_addr   = addr_reg;
  assign dmem_wdata  = wdata_reg;
  assign mem_err     = err_reg;
  assign wb_RegWrite = wb_regwrite_reg;
  assign wb_MemtoReg = wb_memtoreg_reg;
  assign wb_ReadData = wb_readdata_reg;
  assign wb_ALUOut   = wb_aluout_reg;
  assign wb_WriteReg = wb_writereg_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Scoreboard bench for mem_stage_ctrl (TIMEOUT=4). A driver issues one
// instruction at a time and pushes the expected MEM/WB result and, for
// aligned memops, the expected memory request into queues. A monitor pops
// the write-back queue on each retiring edge; a memory responder pops the
// request queue when dmem_req rises and answers after a planned delay.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        err;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    int          len;
  } acc_t;

  logic        CLK;
  logic        RST_N;
  logic        RegWrite, MemtoReg, MemWrite, Branch, zero;
  logic [31:0] ALUOut, WriteData, PCBranch;
  logic [4:0]  WriteReg;
  logic        PCSrc, stall;
  logic [31:0] PCBranchOut;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_err;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_ReadData, wb_ALUOut;
  logic [4:0]  wb_WriteReg;

  wb_t  wb_q[$];
  acc_t acc_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  bit   late_ack = 1'b0;

  mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .Branch      (Branch),
    .zero        (zero),
    .ALUOut      (ALUOut),
    .WriteData   (WriteData),
    .WriteReg    (WriteReg),
    .PCBranch    (PCBranch),
    .PCSrc       (PCSrc),
    .PCBranchOut (PCBranchOut),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .mem_err     (mem_err),
    .wb_RegWrite (wb_RegWrite),
    .wb_MemtoReg (wb_MemtoReg),
    .wb_ReadData (wb_ReadData),
    .wb_ALUOut   (wb_ALUOut),
    .wb_WriteReg (wb_WriteReg)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: one instruction's expected outcome from the rules.
  //   plain op           -> retires after 1 edge, write-back = inputs
  //   misaligned memop   -> 1 edge, RegWrite squashed, mem_err
  //   aligned memop      -> 2 + (ack cycle, or TMO if never acked) edges;
  //                         load data on success, squash + mem_err on timeout
  task automatic issue(input logic rw, input logic mtr, input logic mw,
                       input logic br, input logic z,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pcb, input logic [4:0] wr,
                       input int delay, input logic [31:0] rd);
    logic memop, misal, s;
    int   exp_edges, edges, len;
    wb_t  e;
    acc_t a;
    memop = mtr | mw;
    misal = memop && (alu[1:0] != 2'b00);
    e.rw = rw; e.mtr = mtr; e.alu = alu; e.wr = wr; e.rd = '0; e.err = 1'b0;
    exp_edges = 1;
    if (misal) begin
      e.rw = 1'b0;
      e.err = 1'b1;
    end else if (memop) begin
      len = (delay <= TMO) ? delay : TMO;
      exp_edges = len + 2;
      if (delay <= TMO) begin
        if (!mw) e.rd = rd;
      end else begin
        e.rw = 1'b0;
        e.err = 1'b1;
      end
      a.we = mw; a.addr = alu; a.wdata = wd;
      a.delay = delay; a.rdata = rd; a.len = len;
      acc_q.push_back(a);
    end
    wb_q.push_back(e);
    RegWrite = rw; MemtoReg = mtr; MemWrite = mw; Branch = br; zero = z;
    ALUOut = alu; WriteData = wd; PCBranch = pcb; WriteReg = wr;
    mon_en = 1'b1;
    edges = 0;
    s = 1'b1;
    for (int c = 0; c < 200 && s; c++) begin
      #1;
      s = stall;
      chk("stall", 32'(stall), 32'(c < exp_edges - 1));
      if (c == 0) begin
        chk("pcsrc_first", 32'(PCSrc), 32'(br & z & ~memop));
        chk("pcbranchout", PCBranchOut, pcb);
      end else begin
        chk("pcsrc_busy", 32'(PCSrc), 32'd0);
      end
      @(negedge CLK);
      edges++;
    end
    chk("latency", 32'(edges), 32'(exp_edges));
  endtask

  // Monitor: each edge either retires one instruction (stall was 0) or
  // writes a bubble (stall was 1).
  initial begin
    bit  pend_valid;
    bit  pend_stall;
    wb_t e;
    pend_valid = 1'b0;
    pend_stall = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (!mon_en || !RST_N) begin
        pend_valid = 1'b0;
        continue;
      end
      if (pend_valid) begin
        if (pend_stall) begin
          chk("bubble_RegWrite", 32'(wb_RegWrite), 32'd0);
          chk("bubble_MemtoReg", 32'(wb_MemtoReg), 32'd0);
          chk("bubble_mem_err", 32'(mem_err), 32'd0);
        end else if (wb_q.size() == 0) begin
          n_checks++;
          $display("FAIL wb_unexpected: retirement with empty queue, wb_ALUOut 0x%08h", wb_ALUOut);
        end else begin
          e = wb_q.pop_front();
          $display("retire: rw=%0d mtr=%0d wr=%0d alu=%08h rd=%08h err=%0d",
                   wb_RegWrite, wb_MemtoReg, wb_WriteReg, wb_ALUOut, wb_ReadData, mem_err);
          chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
          chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(e.mtr));
          chk("wb_ReadData", wb_ReadData, e.rd);
          chk("wb_ALUOut", wb_ALUOut, e.alu);
          chk("wb_WriteReg", 32'(wb_WriteReg), 32'(e.wr));
          chk("mem_err", 32'(mem_err), 32'(e.err));
        end
      end
      pend_stall = stall;
      pend_valid = 1'b1;
    end
  end

  // Memory responder: checks each request against the expected access and
  // acks on the planned REQ cycle. Stray acks while idle must be ignored.
  initial begin
    acc_t cur;
    int   cyc;
    bit   active;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    active = 1'b0;
    cyc = 0;
    cur = '{default: '0};
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        active = 1'b0;
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        if (!active) begin
          active = 1'b1;
          cyc = 0;
          if (acc_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: dmem_req=1 with nothing outstanding, addr 0x%08h", dmem_addr);
            cur = '{default: '0};
            cur.len = -1;
          end else begin
            cur = acc_q.pop_front();
          end
        end
        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_wdata", dmem_wdata, cur.wdata);
        cyc++;
        dmem_ack = (cyc == cur.delay);
        dmem_rdata = dmem_ack ? cur.rdata : $urandom;
      end else begin
        if (active) begin
          chk("req_cycles", 32'(cyc), 32'(cur.len));
          active = 1'b0;
        end
        dmem_ack = late_ack | ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Stimulus
  initial begin
    int          kind, delay;
    logic        rw, mtr, mw, br, z;
    logic [31:0] alu, wd, pcb, rd;
    logic [4:0]  wr;

    RST_N = 1'b1;
    RegWrite = 0; MemtoReg = 0; MemWrite = 0; Branch = 0; zero = 0;
    ALUOut = '0; WriteData = '0; PCBranch = '0; WriteReg = '0;
    #1 RST_N = 1'b0;
    #2;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    chk("rst_wb_ReadData", wb_ReadData, 32'd0);
    chk("rst_wb_ALUOut", wb_ALUOut, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (3) @(negedge CLK);
    #3 RST_N = 1'b1;
    @(negedge CLK);

    // Directed cases
    issue(1, 0, 0, 0, 0, 32'h0000_0055, 32'h0, 32'h0, 5'd9, 0, 32'h0);          // R-type
    issue(1, 1, 0, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 5'd5, 2, 32'hDEAD_BEEF);  // load, ack on 2nd REQ
    issue(1, 0, 1, 0, 0, 32'h0000_0204, 32'h1234_5678, 32'h0, 5'd0, 1, 32'h0);  // store, immediate ack
    issue(1, 1, 0, 0, 0, 32'h0000_0102, 32'h0, 32'h0, 5'd7, 1, 32'h1);          // misaligned load
    issue(1, 1, 0, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 5'd3, 99, 32'hCAFE);      // timeout
    issue(0, 0, 0, 1, 1, 32'h0000_0077, 32'h0, 32'h0000_0040, 5'd4, 0, 32'h0);  // taken branch

    // Reset while an access is outstanding
    #3;
    mon_en = 1'b0;
    RegWrite = 1; MemtoReg = 1; MemWrite = 0; Branch = 0; zero = 0;
    ALUOut = 32'h400; WriteData = '0; WriteReg = 5'd12;
    acc_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, delay: 1000, rdata: 32'h0, len: 0});
    repeat (3) @(negedge CLK);
    #1 chk("pre_rst_in_req", 32'(dmem_req), 32'd1);
    #2 RST_N = 1'b0;
    RegWrite = 0; MemtoReg = 0; ALUOut = '0; WriteReg = '0;
    #1;
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
    chk("midrst_wb_ALUOut", wb_ALUOut, 32'd0);
    chk("midrst_wb_WriteReg", 32'(wb_WriteReg), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    wb_q.delete();
    acc_q.delete();
    repeat (2) @(negedge CLK);
    #3 RST_N = 1'b1;
    late_ack = 1'b1;
    @(negedge CLK);
    #1 late_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk("postrst_dmem_req", 32'(dmem_req), 32'd0);
      chk("postrst_stall", 32'(stall), 32'd0);
      chk("postrst_wb_RegWrite", 32'(wb_RegWrite), 32'd0);
      chk("postrst_mem_err", 32'(mem_err), 32'd0);
    end
    @(negedge CLK);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      rw = 1'($urandom); z = 1'($urandom);
      wr = 5'($urandom); wd = $urandom; pcb = $urandom; rd = $urandom;
      alu = $urandom;
      delay = int'($urandom_range(1, 6));
      mtr = 1'b0; mw = 1'b0; br = 1'b0;
      case (kind)
        0, 1, 2: ;
        3, 4: begin mtr = 1'b1; alu[1:0] = 2'b00; end
        5, 6: begin mw = 1'b1; alu[1:0] = 2'b00; end
        7: begin
          if ($urandom_range(0, 1) == 0) mtr = 1'b1; else mw = 1'b1;
          alu[1:0] = 2'($urandom_range(1, 3));
        end
        8: br = 1'b1;
        default: begin br = 1'b1; z = 1'b1; mtr = 1'b1; alu[1:0] = 2'b00; end
      endcase
      issue(rw, mtr, mw, br, z, alu, wd, pcb, wr, delay, rd);
    end

    #3;
    mon_en = 1'b0;
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
